subtractor_brentkung_pipe: RTL

Pipelined, parameterized-width Brent-Kung prefix subtractor with valid/ready handshakes on both sides. It is the inverse-operation companion to the combinational Brent-Kung adder family: it computes `a - b` as `a + ~b + 1` through the same generate/propagate prefix network. The network is split across three register stages. It sits between a producer and a consumer that may each stall, and it sustains one result per cycle when unstalled.

---
 rtl/prefix_pkg.sv | 22 ++
 rtl/bk_pipe_stage_ctl.sv | 25 ++
 rtl/subtractor_brentkung_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/prefix_pkg.sv
// Shared types and helpers for the Brent-Kung prefix adder/subtractor family.
// A group (g,p) describes carry generate/propagate over a contiguous bit span.
package prefix_pkg;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   // High-index group on the left, adjacent low-index group on the right.
   function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
      pg_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

   function automatic bit width_is_legal(input int width);
      return (width >= 4) && ((width & (width - 1)) == 0);
   endfunction

endpackage

// File: rtl/bk_pipe_stage_ctl.sv
// Valid/ready control for one elastic pipeline stage: the stage may load
// whenever it is empty or its successor is taking the item it holds.
module bk_pipe_stage_ctl (
   input  logic clk,
   input  logic rst_n,
   input  logic valid_up,
   input  logic ready_down,
   output logic valid,
   output logic ready,
   output logic load
);

   assign ready = ~valid | ready_down;
   assign load  = valid_up & ready;

   // NOTE: state updates use <= so every stage samples pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (ready) begin
         valid <= valid_up;
      end
   end

endmodule

// File: rtl/subtractor_brentkung_pipe.sv
// Three-stage pipelined Brent-Kung subtractor computing a + ~b + 1 with
// elastic valid/ready handshakes; S1 = bit p/g, S2 = up-sweep, S3 = down-sweep + sum.
module subtractor_brentkung_pipe
   import prefix_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int LG = $clog2(WIDTH);

   if (!width_is_legal(WIDTH)) begin : g_bad_width
      $fatal(1, "subtractor_brentkung_pipe: WIDTH must be a power of two and >= 4");
   end

   // ---------------------------------------------------------------- control
   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;
   logic ld1, ld2, ld3;

   bk_pipe_stage_ctl u_ctl_s1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_up   (in_valid),
      .ready_down (rdy2),
      .valid      (v1),
      .ready      (rdy1),
      .load       (ld1)
   );

   bk_pipe_stage_ctl u_ctl_s2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_up   (v1),
      .ready_down (rdy3),
      .valid      (v2),
      .ready      (rdy2),
      .load       (ld2)
   );

   bk_pipe_stage_ctl u_ctl_s3 (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_up   (v2),
      .ready_down (out_ready),
      .valid      (v3),
      .ready      (rdy3),
      .load       (ld3)
   );

   assign in_ready  = rdy1;
   assign out_valid = v3;

   // ---------------------------------------------------------------- S1: bit p/g
   pg_t [WIDTH-1:0] s1_nxt;
   pg_t [WIDTH-1:0] s1_pg;

   // NOTE: every variable written here gets a default first so no latch can be inferred.
   always_comb begin
      s1_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s1_nxt[i].p = a[i] ^ ~b[i];
         s1_nxt[i].g = a[i] & ~b[i];
      end
      // Carry-in of 1 folds into the bit-0 generate.
      s1_nxt[0].g = s1_nxt[0].g | s1_nxt[0].p;
   end

   // NOTE: datapath registers carry no reset; their contents only matter while the stage valid bit is set.
   always_ff @(posedge clk) begin
      if (ld1) begin
         s1_pg <= s1_nxt;
      end
   end

   // ---------------------------------------------------------------- S2: up-sweep
   for (genvar k = 0; k <= LG; k++) begin : g_up
      pg_t [WIDTH-1:0] node;
      if (k == 0) begin : g_leaf
         assign node = s1_pg;
      end else begin : g_lvl
         localparam int SPAN = 1 << k;
         localparam int HALF = 1 << (k - 1);
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i % SPAN) == SPAN - 1) begin : g_op
               assign node[i] = pg_combine(g_up[k-1].node[i], g_up[k-1].node[i-HALF]);
            end else begin : g_pass
               assign node[i] = g_up[k-1].node[i];
            end
         end
      end
   end

   pg_t  [WIDTH-1:0] s2_tree;
   logic [WIDTH-1:0] s2_p;

   always_ff @(posedge clk) begin
      if (ld2) begin
         s2_tree <= g_up[LG].node;
         for (int i = 0; i < WIDTH; i++) begin
            s2_p[i] <= s1_pg[i].p;
         end
      end
   end

   // ---------------------------------------------------------------- S3: down-sweep
   // Level j fills the indices sitting halfway between already-complete prefixes.
   for (genvar j = 0; j < LG; j++) begin : g_dn
      pg_t [WIDTH-1:0] node;
      if (j == 0) begin : g_root
         assign node = s2_tree;
      end else begin : g_lvl
         localparam int D    = LG - 1 - j;
         localparam int STEP = 1 << (D + 1);
         localparam int HALF = 1 << D;
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((((i + 1) % STEP) == HALF) && (i >= STEP)) begin : g_op
               assign node[i] = pg_combine(g_dn[j-1].node[i], g_dn[j-1].node[i-HALF]);
            end else begin : g_pass
               assign node[i] = g_dn[j-1].node[i];
            end
         end
      end
   end

   logic [WIDTH-1:0] pre_g;
   logic [WIDTH-1:0] pre_p;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pre
      assign pre_g[i] = g_dn[LG-1].node[i].g;
      assign pre_p[i] = g_dn[LG-1].node[i].p;
   end

   // Only the full-span propagate is consumed; partial-span propagates end here.
   logic unused_pre_p;
   assign unused_pre_p = ^pre_p[WIDTH-2:0];

   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] diff_nxt;
   logic             carry_out;
   logic             ovf_nxt;
   logic             zero_nxt;

   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         carry[i] = pre_g[i-1];
      end
      diff_nxt  = s2_p ^ carry;
      carry_out = pre_g[WIDTH-1];
      // Signed overflow: carry into the sign bit differs from carry out of it.
      ovf_nxt   = carry[WIDTH-1] ^ carry_out;
      // All bits propagating means a == b, i.e. the difference is zero.
      zero_nxt  = pre_p[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else if (ld3) begin
         diff   <= diff_nxt;
         borrow <= ~carry_out;
         ovf    <= ovf_nxt;
         zero   <= zero_nxt;
      end
   end

endmodule
